soomrv_mem_arbiter: RTL and testbench
=====================================

Name: soomrv_mem_arbiter

Overview:
- Shares one single-port core SRAM between two requesters:
  - the Caravel management Wishbone slave port, used to load programs and read back results;
  - the SoomRV core memory port.
- Holds the core in reset until firmware sets the run bit in a control register.
- Sits in user_project_wrapper between the wbs_* bus, the core and the SRAM macro.

Parameters:
- ADDR_W, 10: SRAM word-address width.
- BASE_ADDR, 32'h3000_0000: Wishbone base address of the block.
- STARVE_LIMIT, 8: consecutive contested cycles the core may win before Wishbone is forced a grant.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  WB cycle
- wbs_stb_i  in  1  WB strobe
- wbs_we_i  in  1  WB write
- wbs_sel_i  in  4  WB byte selects
- wbs_adr_i  in  32  WB byte address
- wbs_dat_i  in  32  WB write data
- wbs_ack_o  out  1  WB acknowledge
- wbs_dat_o  out  32  WB read data
- core_req_i  in  1  core access request
- core_we_i  in  1  core write
- core_wm_i  in  4  core byte mask
- core_addr_i  in  ADDR_W  core word address
- core_wdata_i  in  32  core write data
- core_gnt_o  out  1  core request granted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- core_rst_o  out  1  core reset, active-high
- sram_csb_o  out  1  SRAM chip select, active-low
- sram_web_o  out  1  SRAM write enable, active-low
- sram_wmask_o  out  4  SRAM byte mask
- sram_addr_o  out  ADDR_W  SRAM address
- sram_din_o  out  32  SRAM write data
- sram_dout_i  in  32  SRAM read data, 1-cycle latency

Behaviour:
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0;
  - core_gnt_o=0, core_rvalid_o=0;
  - core_rst_o=1;
  - sram_csb_o=1, sram_web_o=1;
  - FSM=IDLE, run=0, starve_cnt=0, stall_cnt=0.
- Address decode is on wbs_adr_i minus BASE_ADDR:
  - SRAM window: offset < 4*2^ADDR_W; word = offset[ADDR_W+1:2].
  - CTRL: offset 0x0010_0000. R/W; bit0=run; write takes effect only if wbs_sel_i[0]. core_rst_o = ~run, registered.
  - STATUS: offset 0x0010_0004. Read-only; bit0=run, [31:16]=stall_cnt.
  - Other offsets: ack, read data 0, write dropped.
- WB FSM states: IDLE, WAIT_GNT, RD_WAIT, ACK.
  - IDLE: accept when cyc&stb&!ack. SRAM target -> WAIT_GNT. Register/unmapped target -> ACK; register write applied and read data latched on that edge.
  - WAIT_GNT: when WB owns the SRAM this cycle, drive the SRAM with WB address/data/sel. Write -> ACK; read -> RD_WAIT.
  - RD_WAIT: latch sram_dout_i into wbs_dat_o -> ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle -> IDLE.
- WB latency: SRAM write, 2 cycles accept-to-ack uncontested. SRAM read, 3 cycles. Register access, 1 cycle.
- Arbitration, evaluated combinationally each cycle:
  - core_rst_o=1: core_req_i ignored, core_gnt_o=0; WB always owns the SRAM.
  - Only one side requesting: that side wins.
  - Both requesting: core wins unless starve_cnt==STARVE_LIMIT, then WB wins.
  - starve_cnt increments when WB is in WAIT_GNT and loses. It clears when WB wins or WB is not waiting. It never exceeds STARVE_LIMIT.
- Core grant and read data:
  - core_gnt_o is combinational and same-cycle; a granted access is issued to the SRAM that cycle.
  - A non-granted core request must be held by the core.
  - core_rvalid_o pulses 1 cycle after a granted read.
  - core_rdata_o = sram_dout_i when core_rvalid_o=1.
- SRAM drive:
  - sram_csb_o=0 only in a cycle with a grant.
  - sram_web_o = ~we of the granted side.
  - Idle cycles: csb=1, other SRAM outputs don't-care.
- Reset mid-transaction: an in-flight WB access is dropped with no ack; the FSM returns to IDLE and run clears.
- Writing run=0 while the core is mid-access: core_rst_o rises next cycle. Any pending core_rvalid_o still pulses once.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - stall_cnt is a 16-bit saturating counter; it increments each cycle core_req_i=1 with core_rst_o=0 and core_gnt_o=0.
  - A write of any value to STATUS with wbs_sel_i[2] clears it.
- Undefined: no counter is built; STATUS[31:16] reads 0; STATUS writes are ignored.

Test Plan:
- Reset state: after reset, core_rst_o=1 and WB write 0xCAFEBABE to SRAM word 5 -> ack 2 cycles after accept. Readback of word 5 returns 0xCAFEBABE with ack 3 cycles after accept.
- Control register: WB write CTRL=1 -> core_rst_o=0 next cycle; CTRL read returns 1. WB write CTRL with sel=4'b0000 -> run unchanged.
- Core-only access: core read of word 5 with no WB traffic -> core_gnt_o same cycle; core_rvalid_o=1 with 0xCAFEBABE next cycle.
- Starvation guard: core requests every cycle while WB reads an SRAM word -> core granted 8 cycles, WB granted on the 9th; ack arrives 11 cycles after accept.
- Performance counter (ARB_PERF_CNT_EN): in the starvation scenario with core_req held the whole time -> STATUS[31:16]=1. Write STATUS with sel[2]=1 -> reads 0.
- Reset and unmapped access:
  - Assert wb_rst_i during WAIT_GNT -> no ack, core_rst_o=1, FSM idle.
  - WB read at offset 0x0020_0000 -> ack after 1 cycle, data 0.

Source files
------------

// File: rtl/soomrv_mem_arbiter.sv
// ============================================================================
// Module  : soomrv_mem_arbiter
// Brief   : Shares one single-port SRAM between the Caravel Wishbone slave
//           port and the SoomRV core; holds the core in reset until run=1.
//           Optional macro ARB_PERF_CNT_EN builds a core stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module soomrv_mem_arbiter #(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_wm_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              core_rst_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [3:0]        sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_din_o,
  input  logic [31:0]       sram_dout_i
);

  localparam logic [31:0] c_SRAM_BYTES = 32'(4) << ADDR_W;
  localparam logic [31:0] c_CTRL_OFF   = 32'h0010_0000;
  localparam logic [31:0] c_STATUS_OFF = 32'h0010_0004;
  localparam int          c_SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_ACK      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              run_q, run_d;
  logic              core_rst_q;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              core_rvalid_q;
  logic [c_SW-1:0]   starve_q, starve_d;
  logic              wb_we_q;
  logic [3:0]        wb_sel_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [31:0]       wb_wdata_q;

  logic [31:0]       w_offset;
  logic              w_sram_hit, w_ctrl_hit, w_status_hit, w_accept;
  logic              w_wb_req, w_core_req, w_wb_win, w_core_gnt;
  logic [15:0]       w_stall;

  assign w_offset     = wbs_adr_i - BASE_ADDR;
  assign w_sram_hit   = (w_offset < c_SRAM_BYTES);
  assign w_ctrl_hit   = (w_offset == c_CTRL_OFF);
  assign w_status_hit = (w_offset == c_STATUS_OFF);
  assign w_accept     = (state_q == S_IDLE) & wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

  // While the core is held in reset its request line is meaningless.
  assign w_wb_req   = (state_q == S_WAIT_GNT);
  assign w_core_req = core_req_i & ~core_rst_q;
  assign w_wb_win   = w_wb_req & (~w_core_req | (starve_q == c_STARVE_MAX));
  assign w_core_gnt = w_core_req & ~w_wb_win;
  assign starve_d   = (w_wb_req & ~w_wb_win) ? starve_q + 1'b1 : '0;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    wb_dat_d = wb_dat_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_sram_hit) begin
            state_d = S_WAIT_GNT;
          end else begin
            state_d = S_ACK;
            if (wbs_we_i) begin
              if (w_ctrl_hit && wbs_sel_i[0]) run_d = wbs_dat_i[0];
            end else if (w_ctrl_hit) begin
              wb_dat_d = {31'b0, run_q};
            end else if (w_status_hit) begin
              wb_dat_d = {w_stall, 15'b0, run_q};
            end else begin
              wb_dat_d = '0;
            end
          end
        end
      end
      S_WAIT_GNT: if (w_wb_win) state_d = wb_we_q ? S_ACK : S_RD_WAIT;
      S_RD_WAIT: begin
        wb_dat_d = sram_dout_i;
        state_d  = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      run_q         <= 1'b0;
      core_rst_q    <= 1'b1;
      wb_dat_q      <= '0;
      core_rvalid_q <= 1'b0;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      core_rst_q    <= ~run_d;
      wb_dat_q      <= wb_dat_d;
      core_rvalid_q <= w_core_gnt & ~core_we_i;
      starve_q      <= starve_d;
    end
  end

  // Request fields are captured once at accept and replayed when granted.
  always_ff @(posedge wb_clk_i) begin
    if (w_accept) begin
      wb_we_q    <= wbs_we_i;
      wb_sel_q   <= wbs_sel_i;
      wb_addr_q  <= w_offset[ADDR_W+1:2];
      wb_wdata_q <= wbs_dat_i;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_q;
  logic        w_stall_clr;

  assign w_stall_clr = w_accept & ~w_sram_hit & wbs_we_i & w_status_hit & wbs_sel_i[2];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_stall_clr) begin
      stall_q <= '0;
    end else if (w_core_req && !w_core_gnt && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign w_stall = stall_q;
`else
  assign w_stall = '0;
`endif

  always_comb begin
    sram_csb_o = ~(w_wb_win | w_core_gnt);
    if (w_wb_win) begin
      sram_web_o   = ~wb_we_q;
      sram_wmask_o = wb_sel_q;
      sram_addr_o  = wb_addr_q;
      sram_din_o   = wb_wdata_q;
    end else begin
      sram_web_o   = ~(w_core_gnt & core_we_i);
      sram_wmask_o = core_wm_i;
      sram_addr_o  = core_addr_i;
      sram_din_o   = core_wdata_i;
    end
  end

  assign wbs_ack_o     = (state_q == S_ACK);
  assign wbs_dat_o     = wb_dat_q;
  assign core_gnt_o    = w_core_gnt;
  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = sram_dout_i;
  assign core_rst_o    = core_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_soomrv_mem_arbiter.sv
// ============================================================================
// Module  : tb_soomrv_mem_arbiter
// Brief   : Self-checking bench for soomrv_mem_arbiter with a behavioural
//           1-cycle-latency SRAM; honours ARB_PERF_CNT_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soomrv_mem_arbiter;

  localparam logic [31:0] c_BASE   = 32'h3000_0000;
  localparam logic [31:0] c_CTRL   = 32'h0010_0000;
  localparam logic [31:0] c_STATUS = 32'h0010_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, wwe = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [3:0]  core_wm = '0;
  logic [9:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_rvalid, core_rst;
  logic [31:0] core_rdata;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [9:0]  saddr;
  logic [31:0] sdin;
  logic [31:0] sdout = '0;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soomrv_mem_arbiter #(.ADDR_W(10), .BASE_ADDR(c_BASE), .STARVE_LIMIT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(wwe), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_req_i(core_req), .core_we_i(core_we), .core_wm_i(core_wm),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .core_rst_o(core_rst),
    .sram_csb_o(csb), .sram_web_o(web), .sram_wmask_o(wmask),
    .sram_addr_o(saddr), .sram_din_o(sdin), .sram_dout_i(sdout)
  );

  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][8*b +: 8] <= sdin[8*b +: 8];
      end else begin
        sdout <= mem[saddr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_dat;
    logic [31:0] exp_dat;
    int          exp_lat;
    logic        exp_rst;
  } vec_t;

  typedef struct {
    logic        chk_dat;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] core_sb_q[$];
  vec_t        vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One WB transaction; latency counted in cycles after the accepting edge.
  task automatic wb_xact(input logic we, input logic [31:0] off, input logic [3:0] s,
                         input logic [31:0] wd, input logic chk_d, input logic [31:0] exp_d,
                         input int exp_lat, input string nm,
                         output int first_loss, output int gnt_cnt);
    exp_t e;
    int   n;
    bit   got;
    e.chk_dat = chk_d; e.dat = exp_d; e.lat = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wwe = we; sel = s; adr = c_BASE + off; wdat = wd;
    @(posedge clk);
    n = 0; got = 0; first_loss = 0; gnt_cnt = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (core_req && !core_gnt && first_loss == 0) first_loss = n;
      else if (core_gnt && first_loss == 0) gnt_cnt++;
      if (ack) got = 1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_lat"}, 32'(n), 32'(e.lat));
      if (e.chk_dat) chk({nm, "_data"}, rdat, e.dat);
    end
    cyc = 1'b0; stb = 1'b0; wwe = 1'b0; sel = '0;
  endtask

  initial begin
    int fl, gc;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    vecs[0]  = '{1, 32'h14,   4'hF, 32'hCAFE_BABE, 0, 32'h0,         2, 1};
    vecs[1]  = '{0, 32'h14,   4'hF, 32'h0,         1, 32'hCAFE_BABE, 3, 1};
    vecs[2]  = '{0, c_CTRL,   4'hF, 32'h0,         1, 32'h0,         1, 1};
    vecs[3]  = '{1, c_CTRL,   4'h1, 32'h1,         0, 32'h0,         1, 0};
    vecs[4]  = '{0, c_CTRL,   4'hF, 32'h0,         1, 32'h1,         1, 0};
    vecs[5]  = '{1, c_CTRL,   4'h0, 32'h0,         0, 32'h0,         1, 0};
    vecs[6]  = '{0, c_CTRL,   4'hF, 32'h0,         1, 32'h1,         1, 0};
    vecs[7]  = '{1, 32'h0020_0000, 4'hF, 32'hFFFF_FFFF, 0, 32'h0,    1, 0};
    vecs[8]  = '{0, 32'h0020_0000, 4'hF, 32'h0,    1, 32'h0,         1, 0};
    vecs[9]  = '{1, 32'h18,   4'h3, 32'h1122_3344, 0, 32'h0,         2, 0};
    vecs[10] = '{0, 32'h18,   4'hF, 32'h0,         1, 32'h0000_3344, 3, 0};
    vecs[11] = '{0, c_STATUS, 4'hF, 32'h0,         1, 32'h0000_0001, 1, 0};
    vecs[12] = '{0, 32'h1000, 4'hF, 32'h0,         1, 32'h0,         1, 0};
    vecs[13] = '{1, 32'hFFC,  4'hF, 32'hDEAD_BEEF, 0, 32'h0,         2, 0};
    vecs[14] = '{0, 32'hFFC,  4'hF, 32'h0,         1, 32'hDEAD_BEEF, 3, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",      {31'b0, ack},         32'd0);
    chk("rst_dat",      rdat,                 32'd0);
    chk("rst_core_gnt", {31'b0, core_gnt},    32'd0);
    chk("rst_rvalid",   {31'b0, core_rvalid}, 32'd0);
    chk("rst_core_rst", {31'b0, core_rst},    32'd1);
    chk("rst_csb",      {31'b0, csb},         32'd1);
    chk("rst_web",      {31'b0, web},         32'd1);

    for (int i = 0; i < 15; i++) begin
      wb_xact(vecs[i].we, vecs[i].off, vecs[i].sel, vecs[i].wdata, vecs[i].chk_dat,
              vecs[i].exp_dat, vecs[i].exp_lat, $sformatf("vec%0d", i), fl, gc);
      chk($sformatf("vec%0d_core_rst", i), {31'b0, core_rst}, {31'b0, vecs[i].exp_rst});
    end

    // Core-only read of word 5, then a core byte-masked write seen from WB.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5;
    core_sb_q.push_back(32'hCAFE_BABE);
    #1;
    chk("core_gnt_same_cycle", {31'b0, core_gnt}, 32'd1);
    chk("core_csb",            {31'b0, csb},      32'd0);
    @(negedge clk);
    core_req = 1'b0;
    chk("core_rvalid", {31'b0, core_rvalid}, 32'd1);
    chk("core_rdata",  core_rdata,           core_sb_q.pop_front());
    @(negedge clk);
    chk("core_rvalid_once", {31'b0, core_rvalid}, 32'd0);
    core_req = 1'b1; core_we = 1'b1; core_wm = 4'b1100; core_addr = 10'd7;
    core_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    core_req = 1'b0; core_we = 1'b0;
    wb_xact(0, 32'h1C, 4'hF, 32'h0, 1, 32'hA5A5_0000, 3, "core_wr", fl, gc);

    // Starvation: core requests every cycle while WB reads word 6.
    wb_xact(1, c_STATUS, 4'b0100, 32'h0, 0, 32'h0, 1, "stall_clr", fl, gc);
    @(negedge clk);
    core_req = 1'b1; core_addr = 10'd5;
    wb_xact(0, 32'h18, 4'hF, 32'h0, 1, 32'h0000_3344, 11, "starve", fl, gc);
    core_req = 1'b0;
    chk("starve_first_loss", 32'(fl), 32'd9);
    chk("starve_core_gnts",  32'(gc), 32'd8);
`ifdef ARB_PERF_CNT_EN
    wb_xact(0, c_STATUS, 4'hF, 32'h0, 1, 32'h0001_0001, 1, "status_stall", fl, gc);
`else
    wb_xact(0, c_STATUS, 4'hF, 32'h0, 1, 32'h0000_0001, 1, "status_stall", fl, gc);
`endif
    wb_xact(1, c_STATUS, 4'b0100, 32'h0, 0, 32'h0, 1, "stall_clr2", fl, gc);
    wb_xact(0, c_STATUS, 4'hF, 32'h0, 1, 32'h0000_0001, 1, "status_clr", fl, gc);

    // Reset while WB is stuck in WAIT_GNT behind the core.
    @(negedge clk);
    core_req = 1'b1; core_addr = 10'd5;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wwe = 1'b0; sel = 4'hF; adr = c_BASE + 32'h14;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      bit seen_ack = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (ack) seen_ack = 1;
      end
      chk("rstmid_no_ack",   {31'b0, seen_ack}, 32'd0);
    end
    chk("rstmid_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rstmid_core_gnt", {31'b0, core_gnt}, 32'd0);
    core_req = 1'b0;
    wb_xact(0, c_CTRL, 4'hF, 32'h0, 1, 32'h0, 1, "rstmid_ctrl", fl, gc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
